// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Instruction-memory program loader. Receives a byte stream
//               (16-bit big-endian word count, then big-endian 32-bit words)
//               over a valid/ready handshake and writes each assembled word
//               into the instruction memory. Holds the core in reset until a
//               complete image has been written.
// Ports       : CLK, RST          clock / async active-high reset
//               start             single-cycle load request
//               in_valid, in_data byte stream input
//               in_ready          byte accepted this cycle when in_valid=1
//               WE, W_Ins, W_Addr instruction-memory write port
//               cpu_rst           reset to the core
//               done, err         load complete / header rejected
// Revision    : 1.0  initial release
// ============================================================================
module im_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        WE,
    output logic [31:0] W_Ins,
    output logic [31:0] W_Addr,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // 17 bits so that MAX_WORDS=65535 compares cleanly against a 16-bit count
    localparam logic [16:0] c_MAX_WORDS = 17'(MAX_WORDS);

    state_t      r_state;
    logic [15:0] r_count;
    logic [15:0] r_widx;
    logic [1:0]  r_bidx;
    logic [31:0] r_word;
    logic        r_cpu_rst;

    logic        w_xfer;
    logic [15:0] w_len;
    logic [15:0] w_widx_nxt;
    logic        w_start_ok;

    assign w_xfer     = in_valid && in_ready;
    // Complete length as it will be once the low byte is taken in LEN_LO
    assign w_len      = {r_count[15:8], in_data};
    assign w_widx_nxt = r_widx + 16'd1;
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_ERROR));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_count   <= 16'd0;
            r_widx    <= 16'd0;
            r_bidx    <= 2'd0;
            r_word    <= 32'd0;
            r_cpu_rst <= 1'b1;
        end else begin
            if (w_start_ok) begin
                r_state   <= S_LEN_HI;
                r_cpu_rst <= 1'b1;
            end else begin
                case (r_state)
                    S_LEN_HI: begin
                        if (w_xfer) begin
                            r_count[15:8] <= in_data;
                            r_state       <= S_LEN_LO;
                        end
                    end
                    S_LEN_LO: begin
                        if (w_xfer) begin
                            r_count[7:0] <= in_data;
                            if (w_len == 16'd0) begin
                                r_state   <= S_DONE;
                                r_cpu_rst <= 1'b0;
                            end else if ({1'b0, w_len} > c_MAX_WORDS) begin
                                r_state <= S_ERROR;
                            end else begin
                                r_bidx  <= 2'd0;
                                r_widx  <= 16'd0;
                                r_state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_xfer) begin
                            // Shift in from the bottom: first byte ends up in [31:24]
                            r_word <= {r_word[23:0], in_data};
                            r_bidx <= r_bidx + 2'd1;
                            if (r_bidx == 2'd3) begin
                                r_state <= S_WRITE;
                            end
                        end
                    end
                    S_WRITE: begin
                        r_widx <= w_widx_nxt;
                        if (w_widx_nxt == r_count) begin
                            r_state   <= S_DONE;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    // All outputs decode registered state only; no in_valid -> in_ready path
    assign in_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                      (r_state == S_DATA);
    assign WE       = (r_state == S_WRITE);
    assign W_Ins    = r_word;
    assign W_Addr   = {14'd0, r_widx, 2'b00};
    assign cpu_rst  = r_cpu_rst;
    assign done     = (r_state == S_DONE);
    assign err      = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: doc/im_loader.md
# im_loader

Program loader for the MIPS core's instruction memory. It accepts a byte stream (length header followed by instruction words) over a valid/ready handshake and assembles big-endian 32-bit words. It drives the instruction-memory write port (write enable, write data, write address) and holds the core in reset until the image is fully written. It sits between the host link (UART receiver or testbench) and the fetch stage's `WE`/`W_Ins` inputs.

## Interface
- `MAX_WORDS`, 256: largest accepted image, in words. Values 1..65535.
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a load. Sampled only in IDLE, DONE or ERROR.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts the byte this cycle. A byte transfers when `in_valid && in_ready`.
- `WE`  out  1  instruction-memory write strobe, one cycle per word.
- `W_Ins`  out  32  instruction word; valid while `WE`=1.
- `W_Addr`  out  32  byte address of the word; valid while `WE`=1.
- `cpu_rst`  out  1  reset to the core. High from reset until a load completes, and during any load.
- `done`  out  1  high in DONE.
- `err`  out  1  high in ERROR.

## Operation
- States are IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE and ERROR.
- IDLE → LEN_HI on `start`.
- DONE/ERROR → LEN_HI on `start`. This starts a reload and sets `cpu_rst`=1 again.
- LEN_HI: accept one byte into count[15:8]; → LEN_LO.
- LEN_LO: accept one byte into count[7:0]. Then:
  - count == 0: → DONE, with no writes.
  - count > `MAX_WORDS`: → ERROR, with no writes.
  - otherwise: clear the byte index and word index; → DATA.
- DATA: accept bytes in big-endian order. The first byte goes to bits [31:24], the last to [7:0]. After the 4th byte → WRITE.
- WRITE, one cycle:
  - `WE`=1, `W_Ins`=assembled word, `W_Addr`={word_index, 2'b00}.
  - Increment word index.
  - If the new index equals count → DONE; else → DATA.
- `in_ready`=1 only in LEN_HI, LEN_LO and DATA. It is 0 in WRITE, so stream bytes wait without loss.
- `cpu_rst`:
  - Cleared on the cycle DONE is entered.
  - Set on the cycle LEN_HI is entered.
  - Stays 1 in ERROR.
- Word index width is 16 bits; `W_Addr`[31:18]=0. Wrap is impossible because count ≤ `MAX_WORDS` ≤ 65535.
- `start` while in LEN_HI, LEN_LO, DATA or WRITE is ignored. A load is not restartable mid-stream except by `RST`.
- `in_valid` with `in_ready`=0 is ignored; no byte is consumed.

## Timing
- Reset values (asynchronous, immediate on `RST` assertion):
  - state IDLE, `cpu_rst`=1.
  - `in_ready`, `WE`, `done`, `err` all 0.
  - `W_Ins`=0, `W_Addr`=0, and all internal counters 0.
- Reset mid-load: a partial image stays in memory; the loader returns to IDLE with `cpu_rst`=1.
- All outputs are registered or decoded from registered state; there is no combinational path from `in_valid` to `in_ready`.
- `start` pulse at edge N → `in_ready`=1 from cycle N+1.
- 4th data byte accepted at edge N → `WE`=1 during cycle N+1 → next byte can be accepted at edge N+2.
- Throughput: with a gap-free stream, one word per 5 cycles.
- Last `WE` cycle at cycle N → `done`=1 and `cpu_rst`=0 from cycle N+1.

## Test plan
- Load of 2 words: start, then bytes 00 02 12 34 56 78 9A BC DE F0 with `in_valid` held high.
  - Expect `WE` pulses with (W_Addr 0, W_Ins 0x12345678) and (W_Addr 4, W_Ins 0x9ABCDEF0).
  - Expect `done`=1 and `cpu_rst`=0 the cycle after the second pulse.
  - Expect exactly 5 cycles between the two `WE` pulses.
- Zero length: start, bytes 00 00 → no `WE`; `done`=1 after the second byte; `cpu_rst` falls.
- Oversize with `MAX_WORDS`=256: header 01 01 → `err`=1, no `WE`, `cpu_rst` stays 1. A following start plus a valid 1-word image then clears `err` and writes address 0.
- Backpressure/gaps: random `in_valid` bubbles plus bytes offered during WRITE → no byte lost or duplicated; words match a scoreboard.
- Reset mid-load: assert `RST` after the 6th byte of a 4-word image.
  - Expect all outputs at reset values, state IDLE, `cpu_rst`=1.
  - A new load then starts at W_Addr 0.
- `start` asserted during DATA and during WRITE is ignored; the image completes normally.
